// File: rtl/pipeline_hazard_unit.sv
// Hazard control for the 5-stage pipeline: scoreboard of in-flight writes, stalls, flushes, forwarding selects.
// Outputs are combinational from the stage records and ID inputs; records and saturating counters are registered.
module pipeline_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wen,
  input  logic              id_load,
  input  logic              id_mem,
  input  logic              id_jump,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              wb_kill,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wen;
    logic              load;
    logic              mem;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } rec_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rec_t ex_q, mem_q, wb_q;
  rec_t id_rec;
  logic freeze;
  logic stall;
  logic data_hazard;

  function automatic logic dep(input rec_t x, input logic [REG_AW-1:0] r);
    return x.valid & x.wen & (x.dest == r) & (r != '0);
  endfunction

  function automatic logic use_hit(input rec_t x, input logic use_rs, input logic [REG_AW-1:0] rs,
                                   input logic use_rt, input logic [REG_AW-1:0] rt);
    return (use_rs & dep(x, rs)) | (use_rt & dep(x, rt));
  endfunction

  // MEM has priority over WB; a load still in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input rec_t ex, input rec_t mem, input rec_t wb,
                                         input logic [REG_AW-1:0] r);
    if (!ex.valid)                   return 2'b00;
    else if (dep(mem, r) && !mem.load) return 2'b01;
    else if (dep(wb, r))             return 2'b10;
    else                             return 2'b00;
  endfunction

  always_comb begin
    freeze = mem_q.valid & mem_q.mem & ~mem_ready;
    if (FWD_EN != 0) begin
      data_hazard = use_hit(ex_q, id_use_rs, id_rs, id_use_rt, id_rt) & ex_q.load;
    end else begin
      data_hazard = use_hit(ex_q, id_use_rs, id_rs, id_use_rt, id_rt) |
                    use_hit(mem_q, id_use_rs, id_rs, id_use_rt, id_rt);
    end
    stall = ~freeze & ~ex_redirect & id_valid & data_hazard;

    pc_we       = ~freeze & ~stall;
    ifid_we     = ~freeze & ~stall;
    idex_we     = ~freeze;
    exmem_we    = ~freeze;
    wb_kill     = freeze;
    // A frozen redirect stays in EX and is acted on once the freeze lifts.
    ifid_flush  = ~freeze & (ex_redirect | (~stall & id_valid & id_jump));
    idex_bubble = ~freeze & (ex_redirect | stall);

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs);
      fwd_b = fwd_sel(ex_q, mem_q, wb_q, ex_q.rt);
    end

    id_rec.valid = id_valid & ~idex_bubble;
    id_rec.dest  = id_dest;
    id_rec.wen   = id_wen;
    id_rec.load  = id_load;
    id_rec.mem   = id_mem;
    id_rec.rs    = id_rs;
    id_rec.rt    = id_rt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_we)  ex_q  <= id_rec;
      if (exmem_we) mem_q <= ex_q;
      wb_q <= freeze ? rec_t'('0) : mem_q;
      if ((freeze || stall) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (ifid_flush && flush_cnt != '1)        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.load, wb_q.mem, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_wen, id_load, id_mem, id_jump;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       ex_redirect, mem_ready;

  logic       pc_we[3], ifid_we[3], idex_we[3], exmem_we[3];
  logic       ifid_flush[3], idex_bubble[3], wb_kill[3];
  logic [1:0] fwd_a[3], fwd_b[3];
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [1:0]  scnt2, fcnt2;

  pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
    .id_load(id_load), .id_mem(id_mem), .id_jump(id_jump), .ex_redirect(ex_redirect),
    .mem_ready(mem_ready), .pc_we(pc_we[0]), .ifid_we(ifid_we[0]), .idex_we(idex_we[0]),
    .exmem_we(exmem_we[0]), .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]),
    .wb_kill(wb_kill[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(scnt0), .flush_cnt(fcnt0));

  pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
    .id_load(id_load), .id_mem(id_mem), .id_jump(id_jump), .ex_redirect(ex_redirect),
    .mem_ready(mem_ready), .pc_we(pc_we[1]), .ifid_we(ifid_we[1]), .idex_we(idex_we[1]),
    .exmem_we(exmem_we[1]), .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]),
    .wb_kill(wb_kill[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(scnt1), .flush_cnt(fcnt1));

  pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
    .id_load(id_load), .id_mem(id_mem), .id_jump(id_jump), .ex_redirect(ex_redirect),
    .mem_ready(mem_ready), .pc_we(pc_we[2]), .ifid_we(ifid_we[2]), .idex_we(idex_we[2]),
    .exmem_we(exmem_we[2]), .ifid_flush(ifid_flush[2]), .idex_bubble(idex_bubble[2]),
    .wb_kill(wb_kill[2]), .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(scnt2), .flush_cnt(fcnt2));

  // ctrl bits: {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, wb_kill}
  localparam logic [15:0] C_NORM   = 16'h0078;
  localparam logic [15:0] C_STALL  = 16'h001A;
  localparam logic [15:0] C_FREEZE = 16'h0001;
  localparam logic [15:0] C_REDIR  = 16'h007E;
  localparam logic [15:0] C_JUMP   = 16'h007C;
  localparam int S_CTRL = 0, S_FWD = 1, S_SCNT = 2, S_FCNT = 3;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] get_out(input int d, input int s);
    logic [15:0] v;
    v = '0;
    case (s)
      S_CTRL: v = {9'd0, pc_we[d], ifid_we[d], idex_we[d], exmem_we[d],
                   ifid_flush[d], idex_bubble[d], wb_kill[d]};
      S_FWD:  v = {12'd0, fwd_a[d], fwd_b[d]};
      S_SCNT: v = (d == 0) ? scnt0 : (d == 1) ? scnt1 : {14'd0, scnt2};
      default: v = (d == 0) ? fcnt0 : (d == 1) ? fcnt1 : {14'd0, fcnt2};
    endcase
    return v;
  endfunction

  exp_t        mon_e;
  logic [15:0] mon_act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      mon_act = get_out(mon_e.dut, mon_e.sig);
      n_chk++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc%0d: got %h expected %h", mon_e.name, mon_e.dut, mon_e.cyc,
                 mon_act, mon_e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int d, input int s, input logic [15:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.sig = s; e.val = v; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_dest = '0;
    id_wen = 0; id_load = 0; id_mem = 0; id_jump = 0; ex_redirect = 0; mem_ready = 1;
  endtask

  task automatic instr(input int rs, input int rt, input bit urs, input bit urt, input int dest,
                       input bit wen, input bit ld, input bit mem, input bit jmp);
    id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_dest = 5'(dest); id_wen = wen; id_load = ld; id_mem = mem; id_jump = jmp;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    step(); step();
    reset = 1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0;
    idle();
    step(); step();
    reset = 1;
    step();
    for (int d = 0; d < 3; d++) begin
      expect_v(d, S_CTRL, C_NORM, "reset_ctrl");
      expect_v(d, S_FWD,  16'h0,  "reset_fwd");
      expect_v(d, S_SCNT, 16'h0,  "reset_scnt");
      expect_v(d, S_FCNT, 16'h0,  "reset_fcnt");
    end
    step();

    // Load-use stall, then WB forwarding of the load result.
    do_reset();
    instr(1, 0, 1, 0, 8, 1, 1, 1, 0);                       // lw r8
    expect_v(0, S_CTRL, C_NORM, "lu_issue");
    step();
    instr(8, 2, 1, 1, 9, 1, 0, 0, 0);                       // add r9,r8,r2
    expect_v(0, S_CTRL, C_STALL, "lu_stall");
    step();
    expect_v(0, S_CTRL, C_NORM, "lu_release");
    expect_v(0, S_FWD, 16'h0, "lu_bubble_fwd");
    step();
    idle();
    expect_v(0, S_FWD, 16'h8, "lu_fwd_wb");
    expect_v(0, S_SCNT, 16'd1, "lu_scnt");
    step();

    // MEM beats WB on both operands.
    do_reset();
    instr(1, 2, 1, 1, 3, 1, 0, 0, 0); step();
    instr(1, 2, 1, 1, 3, 1, 0, 0, 0); step();
    instr(3, 3, 1, 1, 4, 1, 0, 0, 0);
    expect_v(0, S_CTRL, C_NORM, "alu_no_stall");
    step();
    idle();
    expect_v(0, S_FWD, 16'h5, "fwd_mem_prio");
    step();

    // r0 never forwards.
    do_reset();
    instr(1, 2, 1, 1, 0, 1, 0, 0, 0); step();
    instr(1, 2, 1, 1, 0, 1, 0, 0, 0); step();
    instr(0, 0, 1, 1, 4, 1, 0, 0, 0); step();
    idle();
    expect_v(0, S_FWD, 16'h0, "fwd_r0");
    step();

    // Load in MEM does not forward; the older ALU result in WB does.
    do_reset();
    instr(1, 2, 1, 1, 3, 1, 0, 0, 0); step();
    instr(1, 0, 1, 0, 3, 1, 1, 1, 0); step();
    instr(3, 5, 0, 0, 4, 1, 0, 0, 0); step();
    idle();
    expect_v(0, S_FWD, 16'h8, "fwd_skip_mem_load");
    expect_v(1, S_FWD, 16'h0, "nofwd_mode_fwd");
    step();

    // No-forwarding mode: ALU producer stalls the reader for 2 cycles.
    do_reset();
    instr(1, 2, 1, 1, 5, 1, 0, 0, 0); step();
    instr(5, 0, 1, 0, 7, 1, 0, 0, 0);
    expect_v(1, S_CTRL, C_STALL, "nofwd_stall_ex");
    expect_v(0, S_CTRL, C_NORM, "fwd_no_stall_alu");
    step();
    expect_v(1, S_CTRL, C_STALL, "nofwd_stall_mem");
    step();
    expect_v(1, S_CTRL, C_NORM, "nofwd_release");
    expect_v(1, S_SCNT, 16'd2, "nofwd_scnt");
    step();

    // Memory freeze holding a redirect, which fires once mem_ready returns.
    do_reset();
    instr(1, 2, 1, 1, 0, 0, 0, 1, 0); step();               // sw
    instr(3, 4, 1, 1, 0, 0, 0, 0, 0); step();               // branch
    instr(0, 0, 0, 0, 6, 1, 0, 0, 0);
    ex_redirect = 1;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      expect_v(0, S_CTRL, C_FREEZE, "freeze_ctrl");
      if (i == 2) expect_v(0, S_SCNT, 16'd2, "freeze_scnt_mid");
      step();
    end
    mem_ready = 1;
    expect_v(0, S_CTRL, C_REDIR, "freeze_redirect_release");
    step();
    idle();
    expect_v(0, S_SCNT, 16'd3, "freeze_scnt");
    expect_v(0, S_FCNT, 16'd1, "freeze_fcnt");
    step();

    // Redirect overrides load-use stall and jump.
    do_reset();
    instr(1, 0, 1, 0, 8, 1, 1, 1, 0); step();
    instr(8, 2, 1, 1, 9, 1, 0, 0, 1);
    ex_redirect = 1;
    expect_v(0, S_CTRL, C_REDIR, "redir_prio");
    step();
    idle();
    expect_v(0, S_FCNT, 16'd1, "redir_fcnt");
    expect_v(0, S_SCNT, 16'd0, "redir_scnt");
    step();

    // 2-bit counters saturate; async reset mid-freeze.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      instr(0, 0, 0, 0, 0, 0, 0, 0, 1);
      expect_v(2, S_CTRL, C_JUMP, "jump_flush");
      if (i == 2) expect_v(2, S_FCNT, 16'd2, "fcnt_2");
      if (i == 3) expect_v(2, S_FCNT, 16'd3, "fcnt_3");
      step();
    end
    idle();
    expect_v(2, S_FCNT, 16'd3, "fcnt_saturate");
    step();
    instr(1, 2, 1, 1, 0, 0, 0, 1, 0); step();
    idle(); step();
    mem_ready = 0;
    expect_v(2, S_CTRL, C_FREEZE, "sat_freeze");
    step();
    expect_v(2, S_CTRL, C_FREEZE, "sat_freeze2");
    expect_v(2, S_SCNT, 16'd1, "sat_scnt1");
    step();
    expect_v(2, S_CTRL, C_NORM, "async_rst_ctrl");
    expect_v(2, S_SCNT, 16'd0, "async_rst_scnt");
    expect_v(2, S_FCNT, 16'd0, "async_rst_fcnt");
    #2 reset = 0;
    step();
    reset = 1;
    expect_v(2, S_CTRL, C_NORM, "post_rst_records");
    step();
    expect_v(2, S_CTRL, C_NORM, "post_rst_records2");
    expect_v(2, S_SCNT, 16'd0, "post_rst_scnt");
    step();
    step();

    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the fixed forwarding, stall and flush logic of the 5-stage MIPS pipeline. It is one block that owns all pipeline hazard control.
- It keeps its own per-stage scoreboard (EX/MEM/WB) of in-flight register writes and issues PC/pipeline-register write enables, bubbles, flushes and forwarding selects.
- It adds three things the earlier logic lacks: a variable-latency data-memory freeze (ready handshake), a no-forwarding mode, and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width (2**REG_AW architectural registers; register 0 is hardwired zero).
- FWD_EN, 1, 1 = forward from MEM/WB; 0 = stall ID until the producer has left MEM.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt.
- id_dest  in  REG_AW  destination register (after RegDst selection).
- id_wen  in  1  instruction writes the register file.
- id_load  in  1  instruction is a load.
- id_mem  in  1  instruction is a load or a store.
- id_jump  in  1  unconditional jump decoded in ID.
- ex_redirect  in  1  taken branch or jr resolved in EX.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- pc_we, ifid_we, idex_we, exmem_we  out  1  pipeline-register write enables.
- ifid_flush  out  1  the IF/ID register loads a NOP.
- idex_bubble  out  1  the ID/EX register loads a NOP (control signals zeroed).
- wb_kill  out  1  suppress the register-file write this cycle.
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = MEM ALU result, 10 = WB write data.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Scoreboard: each of the EX, MEM and WB records holds {valid, dest, wen, load, mem, rs, rt}.
  - On each enabled edge, ID→EX→MEM→WB advance.
  - EX takes the ID fields with valid = id_valid & !idex_bubble.
- Reset (reset = 0, async):
  - All records are invalid and the counters are 0.
  - With idle inputs, the outputs are: pc_we = ifid_we = idex_we = exmem_we = 1; ifid_flush = idex_bubble = wb_kill = 0; fwd_a = fwd_b = 00.
- Definitions:
  - dep(X, r): X.valid & X.wen & X.dest == r & r != 0.
  - use_hit(X): (id_use_rs & dep(X, id_rs)) | (id_use_rt & dep(X, id_rt)).
- freeze = MEM.valid & MEM.mem & !mem_ready. This has the highest priority.
  - pc_we = ifid_we = idex_we = exmem_we = 0, and wb_kill = 1.
  - WB becomes invalid on the edge; EX and MEM hold.
  - ifid_flush = idex_bubble = 0, and ex_redirect is ignored.
  - A redirect in EX is held in place and acted on in the first non-frozen cycle.
- Redirect (no freeze, ex_redirect = 1):
  - ifid_flush = 1, idex_bubble = 1, pc_we = 1.
  - It overrides both the data stall and id_jump.
- Data stall (no freeze, no redirect, id_valid):
  - FWD_EN = 1: stall when use_hit(EX) & EX.load (load-use, exactly 1 cycle).
  - FWD_EN = 0: stall when use_hit(EX) | use_hit(MEM). The register file writes through, so WB is not a hazard.
  - While stalled: pc_we = 0, ifid_we = 0, idex_bubble = 1.
- Jump (no freeze, no redirect, no stall, id_valid & id_jump):
  - ifid_flush = 1 (a single slot).
- Forwarding (FWD_EN = 1; otherwise fwd_a = fwd_b = 00):
  - fwd_a = 01 if dep(MEM, EX.rs) & !MEM.load.
  - Otherwise fwd_a = 10 if dep(WB, EX.rs).
  - Otherwise fwd_a = 00.
  - fwd_b is the same rule using EX.rt. MEM has priority over WB.
  - A load in MEM never forwards, because the load-use stall guarantees the gap.
  - fwd_a and fwd_b are only meaningful when EX.valid; they are forced to 00 otherwise.
- Counters:
  - stall_cnt increments on every freeze or data-stall cycle.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - Both saturate at all-ones and do not wrap.
- All outputs except the counters are combinational from the records plus the inputs. Counters and records are registered.
- A reset assertion mid-freeze or mid-stall clears everything immediately. There is no pending redirect after reset.

Test Plan:
- FWD_EN = 1: lw r8 in EX, then ID add r9, r8, r2 (use_rs) → one cycle with pc_we = 0, ifid_we = 0, idex_bubble = 1. Next cycle, with the load in WB, the add in EX gets fwd_a = 10. stall_cnt = 1.
- add r3 in MEM, add r3 in WB, EX reads r3 on rs and rt → fwd_a = fwd_b = 01. The same case with dest = r0 → 00.
- FWD_EN = 0: add r5 in EX, ID reads r5 → stall for 2 cycles, then release. stall_cnt = 2.
- sw in MEM, mem_ready held low for 3 cycles, ex_redirect = 1 meanwhile:
  - For those 3 cycles: all write enables 0, wb_kill = 1, no flush.
  - Cycle 4 (mem_ready = 1): ifid_flush = idex_bubble = 1.
  - stall_cnt = 3, flush_cnt = 1.
- ex_redirect = 1 together with a load-use hazard and id_jump → redirect outputs only, pc_we = 1, flush_cnt = 1.
- CNT_W = 2: 5 jump flushes → flush_cnt = 3. Assert reset low mid-freeze → counters 0, all records invalid, pc_we = 1 asynchronously.
